// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps each instruction through IF/ID/EXE/MEM/WB
// and drives the datapath strobes combinationally from the registered state.
module multi_cycle_ctrl #(
  parameter int              OP_W    = 6,
  parameter int              ALUOP_W = 3,
  parameter logic [OP_W-1:0] HALT_OP = OP_W'('h3F)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         PCSrc,
  output logic [2:0]         State
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_M = 3'b010,
    S_MEM   = 3'b011,
    S_WB_L  = 3'b100,
    S_EXE_B = 3'b101,
    S_EXE_A = 3'b110,
    S_WB_A  = 3'b111
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h01);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'('h10);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'('h12);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'('h26);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'('h30);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'('h31);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h34);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'('h35);
  localparam logic [OP_W-1:0] OP_J     = OP_W'('h38);
  localparam logic [OP_W-1:0] OP_JR    = OP_W'('h39);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'('h3A);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  state_e state_q, state_d;

  logic op_sub, op_addiu, op_and, op_ori, op_slt, op_sw, op_lw;
  logic op_beq, op_bne, op_j, op_jr, op_jal;
  logic is_halt, is_arith, is_branch, is_mem;

  assign op_sub    = (Op == OP_SUB);
  assign op_addiu  = (Op == OP_ADDIU);
  assign op_and    = (Op == OP_AND);
  assign op_ori    = (Op == OP_ORI);
  assign op_slt    = (Op == OP_SLT);
  assign op_sw     = (Op == OP_SW);
  assign op_lw     = (Op == OP_LW);
  assign op_beq    = (Op == OP_BEQ);
  assign op_bne    = (Op == OP_BNE);
  assign op_j      = (Op == OP_J);
  assign op_jr     = (Op == OP_JR);
  assign op_jal    = (Op == OP_JAL);
  assign is_halt   = (Op == HALT_OP);
  assign is_arith  = (Op == OP_ADD) | op_sub | op_addiu | op_and | op_ori | op_slt;
  assign is_branch = op_beq | op_bne;
  assign is_mem    = op_lw | op_sw;

  // Jumps, halt and unrecognised opcodes all retire in ID.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID: begin
        if (is_halt)        state_d = S_IF;
        else if (is_branch) state_d = S_EXE_B;
        else if (is_mem)    state_d = S_EXE_M;
        else if (is_arith)  state_d = S_EXE_A;
        else                state_d = S_IF;
      end
      S_EXE_A: state_d = S_WB_A;
      S_EXE_M: state_d = S_MEM;
      S_MEM:   state_d = op_lw ? S_WB_L : S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign State = state_q;

  // Reset masks every strobe and select so an abandoned instruction writes nothing.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    if (!Reset) begin
      IRWre   = (state_q == S_IF);
      PCWre   = (state_q != S_IF) && (state_d == S_IF) && !is_halt;
      ALUSrcB = op_addiu | op_ori | op_lw | op_sw;
      ExtSel  = !op_ori;
      if (op_sub | is_branch) ALUOp = ALU_SUB;
      else if (op_and)        ALUOp = ALU_AND;
      else if (op_ori)        ALUOp = ALU_OR;
      else if (op_slt)        ALUOp = ALU_SLT;
      case (state_q)
        S_ID: begin
          RegWre = op_jal;
          if (op_j | op_jal) PCSrc = 2'b11;
          else if (op_jr)    PCSrc = 2'b10;
        end
        S_EXE_B: PCSrc = ((op_beq && Zero) || (op_bne && !Zero)) ? 2'b01 : 2'b00;
        S_MEM: begin
          mRD       = op_lw;
          mWR       = op_sw;
          DBDataSrc = op_lw;
        end
        S_WB_L: begin
          RegWre    = 1'b1;
          RegDst    = 2'b01;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b1;
        end
        S_WB_A: begin
          RegWre    = 1'b1;
          RegDst    = (op_addiu | op_ori) ? 2'b01 : 2'b10;
          WrRegDSrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: each instruction is modelled as a list of steps
// with the expected strobe vector at every step derived from instruction rules.
module tb_multi_cycle_ctrl;

  logic       CLK;
  logic       Reset;
  logic [5:0] Op;
  logic       Zero;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] State;

  int n_tests = 0;
  int n_fail  = 0;

  multi_cycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .State(State)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {State, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc}
  logic [18:0] obs;
  assign obs = {State, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ExtSel,
                ALUOp, mRD, mWR, DBDataSrc, PCSrc};

  logic [5:0] known_ops [14] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h12, 6'h26, 6'h30,
                                 6'h31, 6'h39, 6'h34, 6'h35, 6'h38, 6'h3A, 6'h3F};

  // ---------------- reference model ----------------
  // class: 0 retire-in-decode, 1 branch, 2 store, 3 arith, 4 load
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h10, 6'h12, 6'h26: return 3;
      6'h30:        return 2;
      6'h31:        return 4;
      6'h34, 6'h35: return 1;
      default:      return 0;
    endcase
  endfunction

  function automatic int n_steps(input logic [5:0] op);
    int len [5] = '{2, 3, 4, 4, 5};
    return len[op_class(op)];
  endfunction

  function automatic logic [2:0] path_state(input logic [5:0] op, input int k);
    int c = op_class(op);
    if (k == 0) return 3'b000;
    if (k == 1) return 3'b001;
    if (c == 1) return 3'b101;
    if (c == 3) return (k == 2) ? 3'b110 : 3'b111;
    if (k == 2) return 3'b010;
    if (k == 3) return 3'b011;
    return 3'b100;
  endfunction

  function automatic logic [18:0] exp_vec(input logic [5:0] op, input logic z, input int k);
    int         c    = op_class(op);
    logic       last = (k == n_steps(op) - 1);
    logic       wb   = (c == 3 && k == 3) || (c == 4 && k == 4);
    logic [1:0] rdst = 2'b00;
    logic [2:0] aop  = 3'b000;
    logic [1:0] psrc = 2'b00;
    if (c == 3 && k == 3) rdst = (op == 6'h02 || op == 6'h12) ? 2'b01 : 2'b10;
    if (c == 4 && k == 4) rdst = 2'b01;
    case (op)
      6'h01, 6'h34, 6'h35: aop = 3'b001;
      6'h10:               aop = 3'b010;
      6'h12:               aop = 3'b011;
      6'h26:               aop = 3'b100;
      default:             aop = 3'b000;
    endcase
    if (k == 1 && (op == 6'h38 || op == 6'h3A)) psrc = 2'b11;
    if (k == 1 && op == 6'h39) psrc = 2'b10;
    if (c == 1 && k == 2 && ((op == 6'h34 && z) || (op == 6'h35 && !z))) psrc = 2'b01;
    return {path_state(op, k),
            last && (op != 6'h3F),
            k == 0,
            wb || (op == 6'h3A && k == 1),
            rdst,
            wb,
            (op == 6'h02 || op == 6'h12 || op == 6'h30 || op == 6'h31),
            op != 6'h12,
            aop,
            (op == 6'h31 && k == 3),
            (op == 6'h30 && k == 3),
            (op == 6'h31 && k >= 3),
            psrc};
  endfunction

  function automatic logic is_known(input logic [5:0] op);
    foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scenarios ----------------
  // Every scenario starts and ends mid-cycle (just after negedge) in IF.
  task automatic test_reset();
    Reset = 1'b1; Op = 6'h00; Zero = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    n_tests++;
    if (obs !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 19'b0);
    end
    Reset = 1'b0; #1;
    n_tests++;
    if (obs !== exp_vec(6'h00, 1'b0, 0)) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, exp_vec(6'h00, 1'b0, 0));
    end
  endtask

  task automatic test_instr(input string name, input logic [5:0] op, input logic z);
    logic [18:0] e;
    Op = op; Zero = z; #1;
    for (int k = 0; k < n_steps(op); k++) begin
      e = exp_vec(op, z, k);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s op=%h step=%0d: got %b expected %b", name, op, k, obs, e);
      end
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    test_instr("beq_taken",     6'h34, 1'b1);
    test_instr("beq_not_taken", 6'h34, 1'b0);
    test_instr("bne_taken",     6'h35, 1'b0);
    test_instr("bne_not_taken", 6'h35, 1'b1);
  endtask

  task automatic test_reset_mid_sw();
    logic [18:0] e;
    Op = 6'h30; Zero = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      e = exp_vec(6'h30, 1'b0, k);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sw_pre_reset step=%0d: got %b expected %b", k, obs, e);
      end
      if (k < 3) begin
        @(negedge CLK); #1;
      end
    end
    Reset = 1'b1; #1;
    n_tests++;
    if (obs !== {3'b011, 16'b0}) begin
      n_fail++;
      $display("FAIL sw_reset_in_mem: got %b expected %b", obs, {3'b011, 16'b0});
    end
    @(negedge CLK); #1;
    n_tests++;
    if (obs !== 19'b0) begin
      n_fail++;
      $display("FAIL sw_reset_after_edge: got %b expected %b", obs, 19'b0);
    end
    Reset = 1'b0; #1;
  endtask

  task automatic test_halt();
    logic [18:0] e;
    Op = 6'h3F; Zero = 1'b0; #1;
    for (int c = 0; c < 20; c++) begin
      e = exp_vec(6'h3F, 1'b0, c % 2);
      n_tests++;
      if (obs !== e || PCWre !== 1'b0) begin
        n_fail++;
        $display("FAIL halt cycle=%0d: got %b expected %b", c, obs, e);
      end
      @(negedge CLK); #1;
    end
    Reset = 1'b1; #1;
    @(negedge CLK); #1;
    n_tests++;
    if (obs !== 19'b0) begin
      n_fail++;
      $display("FAIL halt_exit_reset: got %b expected %b", obs, 19'b0);
    end
    Reset = 1'b0; #1;
  endtask

  task automatic test_random(input int n_instr);
    logic [5:0] op;
    logic       z;
    int         r;
    for (int i = 0; i < n_instr; i++) begin
      r = $urandom_range(0, 14);
      if (r == 14) begin
        op = 6'($urandom_range(0, 63));
        while (is_known(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = known_ops[r];
      end
      z = 1'($urandom_range(0, 1));
      test_instr(is_known(op) ? "random" : "random_unknown", op, z);
    end
  endtask

  initial begin
    Reset = 1'b1; Op = 6'h00; Zero = 1'b0;
    test_reset();
    test_instr("add",   6'h00, 1'b0);
    test_instr("lw",    6'h31, 1'b0);
    test_branch();
    test_instr("jal",   6'h3A, 1'b0);
    test_instr("j",     6'h38, 1'b0);
    test_instr("jr",    6'h39, 1'b0);
    test_instr("ori",   6'h12, 1'b0);
    test_instr("addiu", 6'h02, 1'b0);
    test_instr("unknown", 6'h05, 1'b0);
    test_reset_mid_sw();
    test_halt();
    test_random(80);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
